ad_scan_ctrl: RTL and testbench

Parametrised multi-channel AD scan controller. Steps a channel-select address through CH_N inputs and waits a programmable settle time on each. It captures one DATA_W sample per channel for SCANS full passes and buffers the samples in an internal FIFO. It can also append CR/LF terminators, and it sits between the analog mux/ADC front end and the UART/readout path.

---
 rtl/ad_scan_pkg.sv | 20 ++
 rtl/scan_fifo.sv | 58 +++++
 rtl/ad_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_ad_scan_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_scan_pkg.sv
// Shared types and constants for the AD scan controller and its sample FIFO.
package ad_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_TERM_CR = 3'd3,
    ST_TERM_LF = 3'd4,
    ST_DONE    = 3'd5
  } scan_state_e;

  localparam logic [7:0] CR_CODE = 8'h0D;
  localparam logic [7:0] LF_CODE = 8'h0A;

  localparam int unsigned TERM_NONE  = 0;
  localparam int unsigned TERM_FINAL = 1;
  localparam int unsigned TERM_EVERY = 2;

endpackage

// File: rtl/scan_fifo.sv
// Single-clock sample FIFO with registered (non-show-ahead) read data,
// occupancy count and a per-cycle dropped-write indication.
module scan_fifo #(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned FIFO_DEPTH = 4096,
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH),
  localparam int unsigned LVL_W      = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              wr_drop
);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(FIFO_DEPTH));
  // Full blocks the write even when a read frees a slot in the same cycle.
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign wr_drop = wr_en & full;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ad_scan_ctrl.sv
// Multi-channel AD scan controller: settles on each mux channel, captures one
// sample per channel for SCANS passes into a FIFO, optionally adding CR/LF.
module ad_scan_ctrl
  import ad_scan_pkg::*;
#(
  parameter  int unsigned DATA_W     = 8,
  parameter  int unsigned CH_N       = 32,
  parameter  int unsigned SCANS      = 10,
  parameter  int unsigned SETTLE     = 100000,
  parameter  int unsigned FIFO_DEPTH = 4096,
  parameter  int unsigned TERM_MODE  = 1,
  localparam int unsigned ADDR_W     = $clog2(CH_N),
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] sample,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [2:0]        state_o
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned SCN_W = (SCANS > 1) ? $clog2(SCANS) : 1;

  scan_state_e       state;
  scan_state_e       state_nx;
  logic [SET_W-1:0]  settle_cnt;
  logic [SCN_W-1:0]  scan_cnt;
  logic              run_end;
  logic              last_ch;
  logic              last_scan;
  logic              wr_req;
  logic [DATA_W-1:0] wr_word;
  logic              wr_en;
  logic              wr_drop;

  assign last_ch   = (addr == ADDR_W'(CH_N - 1));
  assign last_scan = (scan_cnt == SCN_W'(SCANS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_req   = 1'b0;
    wr_word  = sample;
    unique case (state)
      ST_IDLE:    if (start) state_nx = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == SET_W'(SETTLE - 1)) state_nx = ST_CAPTURE;
      ST_CAPTURE: begin
        wr_req = 1'b1;
        if (!last_ch)
          state_nx = ST_SETTLE;
        else if (!last_scan)
          state_nx = (TERM_MODE == TERM_EVERY) ? ST_TERM_CR : ST_SETTLE;
        else
          state_nx = (TERM_MODE != TERM_NONE) ? ST_TERM_CR : ST_DONE;
      end
      ST_TERM_CR: begin
        wr_req   = 1'b1;
        wr_word  = DATA_W'(CR_CODE);
        state_nx = ST_TERM_LF;
      end
      ST_TERM_LF: begin
        wr_req   = 1'b1;
        wr_word  = DATA_W'(LF_CODE);
        state_nx = run_end ? ST_DONE : ST_SETTLE;
      end
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
    if (state != ST_IDLE && abort) state_nx = ST_IDLE;
  end

  // Abort suppresses whatever write the current state would make.
  assign wr_en = wr_req & ~abort;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr       <= '0;
      scan_cnt   <= '0;
      settle_cnt <= '0;
      run_end    <= 1'b0;
      overflow   <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      addr       <= '0;
      scan_cnt   <= '0;
      settle_cnt <= '0;
      run_end    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_drop) overflow <= 1'b1;
      if (state == ST_SETTLE && state_nx == ST_SETTLE)
        settle_cnt <= settle_cnt + SET_W'(1);
      else
        settle_cnt <= '0;
      if (state == ST_CAPTURE && !abort) begin
        if (last_ch) begin
          addr <= '0;
          if (last_scan) run_end  <= 1'b1;
          else           scan_cnt <= scan_cnt + SCN_W'(1);
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end
    end
  end

  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE) && !abort;
  assign state_o = state;

  scan_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .wr_drop (wr_drop)
  );

endmodule

// File: tb/tb_ad_scan_ctrl.sv
// Bench for ad_scan_ctrl: three configurations (terminator modes 1/2/0, the
// last with an 8-word FIFO) checked against a timeline/queue reference model.
module tb_ad_scan_ctrl;

  localparam int unsigned CH = 4;
  localparam int unsigned ST = 3;
  localparam int unsigned P_SCANS [3] = '{2, 2, 3};
  localparam int unsigned P_MODE  [3] = '{1, 2, 0};
  localparam int unsigned P_DEPTH [3] = '{16, 16, 8};

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, abort, rd_en;
  logic [7:0] sample;
  logic [1:0] sel;

  always #5 clk = ~clk;

  logic [2:0] start_v, abort_v, rd_v;
  assign start_v = {start & (sel == 2'd2), start & (sel == 2'd1), start & (sel == 2'd0)};
  assign abort_v = {abort & (sel == 2'd2), abort & (sel == 2'd1), abort & (sel == 2'd0)};
  assign rd_v    = {rd_en & (sel == 2'd2), rd_en & (sel == 2'd1), rd_en & (sel == 2'd0)};

  logic [1:0] addr_v  [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic [7:0] rdd_v   [3];
  logic       empty_v [3];
  logic       full_v  [3];
  logic       ovf_v   [3];
  logic [2:0] st_v    [3];
  logic [4:0] lvl_a, lvl_b;
  logic [3:0] lvl_c;

  ad_scan_ctrl #(.DATA_W(8), .CH_N(CH), .SCANS(2), .SETTLE(ST), .FIFO_DEPTH(16), .TERM_MODE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]), .sample(sample),
    .addr(addr_v[0]), .busy(busy_v[0]), .done(done_v[0]), .rd_en(rd_v[0]), .rd_data(rdd_v[0]),
    .empty(empty_v[0]), .full(full_v[0]), .level(lvl_a), .overflow(ovf_v[0]), .state_o(st_v[0]));

  ad_scan_ctrl #(.DATA_W(8), .CH_N(CH), .SCANS(2), .SETTLE(ST), .FIFO_DEPTH(16), .TERM_MODE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]), .sample(sample),
    .addr(addr_v[1]), .busy(busy_v[1]), .done(done_v[1]), .rd_en(rd_v[1]), .rd_data(rdd_v[1]),
    .empty(empty_v[1]), .full(full_v[1]), .level(lvl_b), .overflow(ovf_v[1]), .state_o(st_v[1]));

  ad_scan_ctrl #(.DATA_W(8), .CH_N(CH), .SCANS(3), .SETTLE(ST), .FIFO_DEPTH(8), .TERM_MODE(0)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort_v[2]), .sample(sample),
    .addr(addr_v[2]), .busy(busy_v[2]), .done(done_v[2]), .rd_en(rd_v[2]), .rd_data(rdd_v[2]),
    .empty(empty_v[2]), .full(full_v[2]), .level(lvl_c), .overflow(ovf_v[2]), .state_o(st_v[2]));

  logic [1:0] m_addr;
  logic       m_busy, m_done, m_empty, m_full, m_ovf;
  logic [7:0] m_rdd;
  logic [2:0] m_state;
  logic [4:0] m_level;

  always_comb begin
    m_addr  = addr_v[sel];
    m_busy  = busy_v[sel];
    m_done  = done_v[sel];
    m_rdd   = rdd_v[sel];
    m_empty = empty_v[sel];
    m_full  = full_v[sel];
    m_ovf   = ovf_v[sel];
    m_state = st_v[sel];
    m_level = (sel == 2'd0) ? lvl_a : (sel == 2'd1) ? lvl_b : {1'b0, lvl_c};
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0] q [$];
  logic [7:0] last_rd [3];
  logic       ov [3];
  logic [7:0] hist [64];
  logic       wv   [64];
  logic [7:0] wd   [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s sel=%0d got=%0h exp=%0h", tag, sel, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned scan_len();
    return CH * (ST + 1) + ((P_MODE[sel] == 2) ? 2 : 0);
  endfunction

  function automatic int unsigned total_len();
    int unsigned pairs;
    pairs = (P_MODE[sel] == 2) ? P_SCANS[sel] : (P_MODE[sel] == 1) ? 1 : 0;
    return P_SCANS[sel] * CH * (ST + 1) + 2 * pairs + 1;
  endfunction

  function automatic int unsigned exp_addr(input int unsigned k);
    int unsigned s, o;
    s = (k - 1) / scan_len();
    if (s > P_SCANS[sel] - 1) s = P_SCANS[sel] - 1;
    o = k - 1 - s * scan_len();
    return (o < CH * (ST + 1)) ? o / (ST + 1) : 0;
  endfunction

  // Expected FIFO writes by cycle number after the start edge.
  task automatic build();
    int unsigned base, t;
    for (int k = 0; k < 64; k++) begin
      hist[k] = 8'($urandom);
      wv[k]   = 1'b0;
      wd[k]   = 8'h00;
    end
    for (int unsigned s = 0; s < P_SCANS[sel]; s++) begin
      base = s * scan_len();
      for (int unsigned c = 0; c < CH; c++) begin
        t = base + c * (ST + 1) + ST + 1;
        wv[t] = 1'b1;
        wd[t] = hist[t];
      end
      if (P_MODE[sel] == 2 || (P_MODE[sel] == 1 && s == P_SCANS[sel] - 1)) begin
        t = base + CH * (ST + 1) + 1;
        wv[t] = 1'b1;     wd[t] = 8'h0D;
        wv[t + 1] = 1'b1; wd[t + 1] = 8'h0A;
      end
    end
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, "_level"}, 32'(m_level), 32'(q.size()));
    chk({tag, "_empty"}, 32'(m_empty), 32'(q.size() == 0));
    chk({tag, "_full"},  32'(m_full),  32'(q.size() == P_DEPTH[sel]));
    chk({tag, "_rdata"}, 32'(m_rdd),   32'(last_rd[sel]));
    chk({tag, "_ovf"},   32'(m_ovf),   32'(ov[sel]));
  endtask

  task automatic run(input int unsigned abort_at, input int unsigned rd_mode);
    int unsigned t, busy_k, pre;
    logic rd;
    bit aborted;
    build();
    t = total_len();
    busy_k = $urandom_range(2, t);
    aborted = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ov[sel] = 1'b0;
    chk("start_ovf_clear", 32'(m_ovf), 32'd0);
    for (int unsigned k = 1; k <= t && !aborted; k++) begin
      sample = hist[k];
      abort  = (k == abort_at);
      start  = (k == busy_k);
      rd = (rd_mode == 1) ? ((k == ST + 1) || ($urandom_range(0, 2) == 0)) : 1'b0;
      rd_en = rd;
      chk("run_addr", 32'(m_addr), exp_addr(k));
      chk("run_busy", 32'(m_busy), 32'd1);
      chk("run_done", 32'(m_done), 32'(k == t && abort_at == 0));
      tick();
      start = 1'b0;
      abort = 1'b0;
      rd_en = 1'b0;
      pre = q.size();
      if (rd && pre > 0) last_rd[sel] = q.pop_front();
      if (wv[k] && k != abort_at) begin
        if (pre < P_DEPTH[sel]) q.push_back(wd[k]);
        else ov[sel] = 1'b1;
      end
      check_fifo("run");
      if (k == abort_at) begin
        aborted = 1;
        chk("abort_busy", 32'(m_busy), 32'd0);
        chk("abort_done", 32'(m_done), 32'd0);
      end
    end
    if (!aborted) begin
      chk("end_busy",  32'(m_busy),  32'd0);
      chk("end_done",  32'(m_done),  32'd0);
      chk("end_addr",  32'(m_addr),  32'd0);
      chk("end_state", 32'(m_state), 32'd0);
    end
  endtask

  task automatic drain();
    rd_en = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      tick();
      last_rd[sel] = q.pop_front();
      check_fifo("drain");
    end
    tick();
    check_fifo("rd_empty");
    rd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"},  32'(m_addr),  32'd0);
    chk({tag, "_busy"},  32'(m_busy),  32'd0);
    chk({tag, "_done"},  32'(m_done),  32'd0);
    chk({tag, "_rdata"}, 32'(m_rdd),   32'd0);
    chk({tag, "_empty"}, 32'(m_empty), 32'd1);
    chk({tag, "_full"},  32'(m_full),  32'd0);
    chk({tag, "_level"}, 32'(m_level), 32'd0);
    chk({tag, "_ovf"},   32'(m_ovf),   32'd0);
    chk({tag, "_state"}, 32'(m_state), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; abort = 1'b0; rd_en = 1'b0; sample = 8'h00; sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 8'h00;
      ov[i] = 1'b0;
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      sel = 2'(i);
      #1;
      check_reset_outputs("reset");
    end
    reset_n = 1'b1;
    tick();

    sel = 2'd0;
    run(0, 0);
    drain();
    run(ST + 2, 0);
    drain();
    run(0, 1);
    drain();

    sel = 2'd1;
    run(0, 1);
    drain();
    run(0, 0);
    drain();

    sel = 2'd2;
    run(0, 0);
    run(0, 1);
    drain();

    sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    last_rd[0] = 8'h00;
    ov[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_fifo("post_reset");
    chk("post_reset_busy", 32'(m_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
